// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract unit:
// controller state encoding and the default datapath width.
package serial_addsub_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// Full_Adder_1: the single 1-bit full-adder cell reused every cycle.
// Ports: a, b, c_in (inputs); sum, c_out (outputs).
module Full_Adder_1 (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial a+b / a-b, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/sub/a/b (request),
//        ready/done (handshake), result/c_out/overflow/zero (held flags).
module serial_addsub_ctrl
   import serial_addsub_ctrl_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   // Holds the WIDTH-1 sum bits produced so far; the final bit
   // is merged in on the last RUN cycle, straight into result.
   logic [WIDTH-2:0] res_sr_q, res_sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cin_msb_q, cin_msb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_out_q, c_out_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] res_full;

   Full_Adder_1 u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      res_sr_d  = res_sr_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      result_d  = result_q;
      c_out_d   = c_out_q;
      zero_d    = zero_q;
      done_d    = 1'b0;
      res_full  = {fa_sum, res_sr_q};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               // Subtraction is a + ~b + 1: invert B, carry-in of 1.
               b_sr_d  = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            res_sr_d = res_full[WIDTH-1:1];
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // MSB cycle: carry_q is the carry into the MSB.
               cnt_d     = cnt_q;
               cin_msb_d = carry_q;
               result_d  = res_full;
               c_out_d   = fa_cout;
               zero_d    = (res_full == '0);
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         res_sr_q  <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         result_q  <= '0;
         c_out_q   <= 1'b0;
         zero_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         res_sr_q  <= res_sr_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         result_q  <= result_d;
         c_out_q   <= c_out_d;
         zero_q    <= zero_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign result   = result_q;
   assign c_out    = c_out_q;
   // Both terms are flops that change only on the DONE entry edge.
   assign overflow = cin_msb_q ^ c_out_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed and random operations
// compared each cycle against an arithmetic model of the unit.
module tb_serial_addsub_ctrl;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done;
   logic [W-1:0] result;
   logic         c_out;
   logic         overflow;
   logic         zero;

   int checks = 0;
   int errors = 0;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 40)
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
      end
   endtask

   // Returns {overflow, zero, c_out, result} from plain wide arithmetic.
   function automatic logic [W+2:0] calc(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic s);
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         ov;
      if (s) full = {1'b0, x} - {1'b0, y} + {1'b1, {W{1'b0}}};
      else   full = {1'b0, x} + {1'b0, y};
      r = full[W-1:0];
      if (s) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      else   ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      return {ov, (r == '0), full[W], r};
   endfunction

   // Behavioural model: accept when idle, done W edges later,
   // ready again one edge after that.
   bit           m_valid = 0;
   bit           m_busy;
   int           m_cyc;
   logic         m_ready, m_done, m_c, m_ov, m_z;
   logic [W-1:0] m_res;
   logic [W+2:0] m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1;
         m_busy  = 0;
         m_cyc   = 0;
         m_ready = 1'b1;
         m_done  = 1'b0;
         m_res   = '0;
         m_c     = 1'b0;
         m_ov    = 1'b0;
         m_z     = 1'b0;
      end else if (m_valid) begin
         if (m_busy) begin
            m_cyc++;
            if (m_cyc == W) begin
               m_done = 1'b1;
               {m_ov, m_z, m_c, m_res} = m_pend;
            end else if (m_cyc == W + 1) begin
               m_done  = 1'b0;
               m_ready = 1'b1;
               m_busy  = 0;
            end
         end else if (start) begin
            m_pend  = calc(a, b, sub);
            m_busy  = 1;
            m_cyc   = 0;
            m_ready = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_ready", 64'(ready), 64'(m_ready));
         chk("m_done", 64'(done), 64'(m_done));
         chk("m_result", 64'(result), 64'(m_res));
         chk("m_c_out", 64'(c_out), 64'(m_c));
         chk("m_overflow", 64'(overflow), 64'(m_ov));
         chk("m_zero", 64'(zero), 64'(m_z));
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) chk("wait_ready_timeout", 64'(0), 64'(1));
   endtask

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input logic [W-1:0] er,
                         input logic ec, input logic eo, input logic ez,
                         input string nm);
      int lat;
      bit got;
      wait_ready();
      a = xa;
      b = xb;
      sub = xs;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      sub = 1'($urandom);
      lat = 1;
      got = 0;
      while (!got && lat < 200) begin
         if (done === 1'b1) got = 1;
         else begin
            chk({nm, "_ready_low"}, 64'(ready), 64'(0));
            @(negedge clk);
            lat++;
         end
      end
      if (!got) chk({nm, "_done_timeout"}, 64'(0), 64'(1));
      else begin
         chk({nm, "_latency"}, 64'(lat), 64'(W + 1));
         chk({nm, "_result"}, 64'(result), 64'(er));
         chk({nm, "_c_out"}, 64'(c_out), 64'(ec));
         chk({nm, "_overflow"}, 64'(overflow), 64'(eo));
         chk({nm, "_zero"}, 64'(zero), 64'(ez));
      end
   endtask

   function automatic logic [W-1:0] rv();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int ndone;
      logic [W+2:0] e;
      logic [W-1:0] ra, rb;
      logic rs;
      rst = 1'b1;
      start = 1'b0;
      sub = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_zero", 64'(zero), 64'(0));

      run_op(32'd5, 32'd3, 1'b0, 32'h8, 0, 0, 0, "add_5_3");
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1, 0, 1, "add_wrap");
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 0, 1, 0, "add_ovf");
      run_op(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, "sub_3_5");
      run_op(32'd5, 32'd5, 1'b1, 32'h0, 1, 0, 1, "sub_5_5");
      run_op(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, "sub_ovf");

      // Starts during RUN must be ignored.
      wait_ready();
      a = 32'd1;
      b = 32'd2;
      sub = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = '1;
      b = '1;
      ndone = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (done === 1'b1) begin
            ndone++;
            start = 1'b0;
         end
         if (ndone == 0) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_done_count", 64'(ndone), 64'(1));
      chk("ign_result", 64'(result), 64'(3));

      // Reset mid-RUN aborts without a done pulse.
      wait_ready();
      a = 32'h7FFF_FFFF;
      b = 32'd1;
      sub = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 64'(ready), 64'(1));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_result", 64'(result), 64'(0));
      chk("abort_c_out", 64'(c_out), 64'(0));
      chk("abort_overflow", 64'(overflow), 64'(0));
      chk("abort_zero", 64'(zero), 64'(0));
      ndone = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (done === 1'b1) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(ndone), 64'(0));
      run_op(32'd10, 32'd20, 1'b0, 32'd30, 0, 0, 0, "after_abort");

      // rst and start on the same edge: start is dropped.
      wait_ready();
      rst = 1'b1;
      start = 1'b1;
      a = 32'd5;
      b = 32'd6;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_start_ready", 64'(ready), 64'(1));
         @(negedge clk);
      end

      for (int i = 0; i < 25; i++) begin
         ra = rv();
         rb = rv();
         rs = 1'($urandom);
         e = calc(ra, rb, rs);
         run_op(ra, rb, rs, e[W-1:0], e[W], e[W+2], e[W+1], "rand");
      end

      // Back-to-back: start held high, operands changing every cycle.
      wait_ready();
      start = 1'b1;
      ndone = 0;
      for (int i = 0; i < 4 * (W + 2); i++) begin
         a = rv();
         b = rv();
         sub = 1'($urandom);
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      start = 1'b0;
      chk("b2b_done_count", 64'(ndone), 64'(4));
      wait_ready();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
